alu_rr_arbiter: RTL

// - Shares one 32-bit ALU logic/arith datapath between two requesters (e.g. issue port, debug port).
// - Accepts one operation at a time over a valid/ready handshake and round-robin arbitrates.
// - Executes the operation over a programmable number of cycles.
// - Returns the registered result plus zero/carry/error flags to the requester that issued it.

---
 rtl/alu_pkg.sv | 29 ++
 rtl/alu_logic_unit.sv | 52 +++++
 rtl/alu_rr_arbiter.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Package   : alu_pkg
// Purpose   : Opcode encodings, FSM state encoding and an opcode legality
//             helper shared by alu_rr_arbiter and alu_logic_unit.
// Revision  : 1.0  initial release
// ============================================================================
package alu_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_NOR = 3'b011;
  localparam logic [2:0] OP_ADD = 3'b100;
  localparam logic [2:0] OP_SUB = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Encodings above OP_SUB (110, 111) are reserved.
  function automatic logic op_is_legal(input logic [2:0] op);
    return (op <= OP_SUB);
  endfunction

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_logic_unit.sv
`default_nettype none
// ============================================================================
// Module    : alu_logic_unit
// Purpose   : Purely combinational logic/arith datapath.
// Ports     : op    [2:0]      opcode
//             a, b  [WIDTH-1:0] operands
//             y     [WIDTH-1:0] result (0 for illegal opcodes)
//             carry             ADD carry-out / SUB not-borrow, else 0
//             err               illegal opcode
// Revision  : 1.0  initial release
// ============================================================================
module alu_logic_unit #(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  output logic             carry,
  output logic             err
);
  import alu_pkg::*;

  logic [WIDTH-1:0] w_b_eff;
  logic             w_cin;
  logic [WIDTH:0]   w_sum;

  // One shared adder: SUB is a + ~b + 1, so its carry-out is NOT-borrow.
  assign w_cin   = (op == OP_SUB);
  assign w_b_eff = w_cin ? ~b : b;
  assign w_sum   = {1'b0, a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, w_cin};

  always_comb begin
    y     = '0;
    carry = 1'b0;
    err   = !op_is_legal(op);
    case (op)
      OP_AND: y = a & b;
      OP_OR:  y = a | b;
      OP_XOR: y = a ^ b;
      OP_NOR: y = ~(a | b);
      OP_ADD,
      OP_SUB: begin
        y     = w_sum[WIDTH-1:0];
        carry = w_sum[WIDTH];
      end
      default: y = '0;
    endcase
  end

endmodule : alu_logic_unit
`default_nettype wire

// File: rtl/alu_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module    : alu_rr_arbiter
// Purpose   : Shares one ALU datapath between two requesters. Round-robin
//             arbitration, one outstanding op, EXEC_CYCLES execution delay,
//             registered result routed back to the issuing requester.
// Ports     : clk, rst (async, active high)
//             reqN_valid/reqN_ready/reqN_op/reqN_a/reqN_b   request channel N
//             rspN_valid/rspN_ready                         response channel N
//             rsp_data, rsp_zero, rsp_carry, rsp_err        shared result
//             busy                                          FSM not idle
// Revision  : 1.0  initial release
// ============================================================================
module alu_rr_arbiter #(
  parameter int WIDTH       = 32,
  parameter int EXEC_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [2:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [2:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_zero,
  output logic             rsp_carry,
  output logic             rsp_err,
  output logic             busy
);
  import alu_pkg::*;

  localparam logic [3:0] C_CNT_INIT = 4'(EXEC_CYCLES - 1);

  state_t           r_state;
  state_t           w_next_state;
  logic             r_prio;
  logic             r_owner;
  logic [3:0]       r_cnt;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;

  logic             w_idle;
  logic             w_grant;
  logic             w_accept;
  logic             w_rsp_hs;
  logic [WIDTH-1:0] w_y;
  logic             w_carry;
  logic             w_err;

  assign w_idle = (r_state == ST_IDLE);

  // Pointer only matters on contention; otherwise the lone valid wins.
  assign w_grant  = (req0_valid && req1_valid) ? r_prio : req1_valid;
  assign req0_ready = w_idle && req0_valid && !w_grant;
  assign req1_ready = w_idle && req1_valid &&  w_grant;
  assign w_accept = req0_ready || req1_ready;

  assign rsp0_valid = (r_state == ST_RESP) && !r_owner;
  assign rsp1_valid = (r_state == ST_RESP) &&  r_owner;
  assign w_rsp_hs   = (rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready);
  assign busy       = !w_idle;

  alu_logic_unit #(
    .WIDTH (WIDTH)
  ) u_alu (
    .op    (r_op),
    .a     (r_a),
    .b     (r_b),
    .y     (w_y),
    .carry (w_carry),
    .err   (w_err)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (w_accept)       w_next_state = ST_EXEC;
      ST_EXEC: if (r_cnt == 4'd0)  w_next_state = ST_RESP;
      ST_RESP: if (w_rsp_hs)       w_next_state = ST_IDLE;
      default:                     w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prio    <= 1'b0;
      r_owner   <= 1'b0;
      r_cnt     <= 4'd0;
      r_op      <= 3'd0;
      r_a       <= '0;
      r_b       <= '0;
      rsp_data  <= '0;
      rsp_zero  <= 1'b0;
      rsp_carry <= 1'b0;
      rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_owner <= w_grant;
            r_op    <= w_grant ? req1_op : req0_op;
            r_a     <= w_grant ? req1_a  : req0_a;
            r_b     <= w_grant ? req1_b  : req0_b;
            r_cnt   <= C_CNT_INIT;
          end
        end
        ST_EXEC: begin
          if (r_cnt == 4'd0) begin
            rsp_data  <= w_y;
            rsp_zero  <= (w_y == '0);
            rsp_carry <= w_carry;
            rsp_err   <= w_err;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        ST_RESP: begin
          // Hand priority to the requester that was not just served.
          if (w_rsp_hs) r_prio <= !r_owner;
        end
        default: ;
      endcase
    end
  end

endmodule : alu_rr_arbiter
`default_nettype wire
